// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the parallel-in/serial-out transmitter.
package piso_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/tx_shift_core.sv
// Shift register, per-word direction flag and bit counter for the serial transmitter.
// Current bit and frame strobes are kept in registers computed from the next shifter contents.
module tx_shift_core
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] word,
    input  logic             dir,
    output logic             tx_bit,
    output logic             first,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] sreg_next_s;
    logic             dir_r;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_next_s;
    logic             bit_r;
    logic             first_r;
    logic             last_r;

    // Drain toward the transmitted end with zero fill, so the shifter is empty after the last bit.
    always_comb begin
        sreg_next_s = sreg_r;
        cnt_next_s  = cnt_r + CW'(1);
        if (cnt_r == CNT_LAST) begin
            cnt_next_s = {CW{1'b0}};
        end else begin
            cnt_next_s = cnt_r + CW'(1);
        end
        if (dir_r == DIR_LSB_FIRST) begin
            sreg_next_s = {1'b0, sreg_r[WIDTH-1:1]};
        end else begin
            sreg_next_s = {sreg_r[WIDTH-2:0], 1'b0};
        end
    end

    // Shifter state and registered bit/strobe images.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_r  <= {WIDTH{1'b0}};
            dir_r   <= DIR_MSB_FIRST;
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (load) begin
            sreg_r  <= word;
            dir_r   <= dir;
            cnt_r   <= {CW{1'b0}};
            bit_r   <= (dir == DIR_LSB_FIRST) ? word[0] : word[WIDTH-1];
            first_r <= 1'b1;
            last_r  <= 1'b0;
        end else if (shift) begin
            sreg_r  <= sreg_next_s;
            cnt_r   <= cnt_next_s;
            bit_r   <= (dir_r == DIR_LSB_FIRST) ? sreg_next_s[0] : sreg_next_s[WIDTH-1];
            first_r <= 1'b0;
            last_r  <= (cnt_next_s == CNT_LAST);
        end else begin
            sreg_r  <= sreg_r;
            dir_r   <= dir_r;
            cnt_r   <= cnt_r;
            bit_r   <= bit_r;
            first_r <= first_r;
            last_r  <= last_r;
        end
    end

    assign tx_bit = bit_r;
    assign first  = first_r;
    assign last   = last_r;

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word intake with a one-word holding
// register, per-word bit order, frame strobes and an optional idle gap between words.
module piso_serial_tx
    import piso_tx_pkg::tx_state_t;
    import piso_tx_pkg::IDLE;
    import piso_tx_pkg::SHIFT;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_dir,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam logic       HAS_GAP  = (GAP > 32'sd0) ? 1'b1 : 1'b0;
    localparam logic [3:0] GAP_LAST = 4'(GAP - 32'sd1);

    tx_state_t        state_r;
    tx_state_t        state_next_s;
    logic [3:0]       gap_cnt_r;
    logic [3:0]       gap_cnt_next_s;
    logic [WIDTH-1:0] hold_word_r;
    logic             hold_dir_r;
    logic             hold_full_r;
    logic             hold_full_next_s;
    logic             accept_s;
    logic             load_s;
    logic             shift_s;
    logic             din_ready_r;
    logic             sout_valid_r;
    logic             busy_r;
    logic             core_bit_s;
    logic             core_first_s;
    logic             core_last_s;

    assign accept_s = din_valid & din_ready_r;

    // Next state: only advances on enabled cycles; word ends reload straight from the holding register.
    always_comb begin
        state_next_s   = state_r;
        gap_cnt_next_s = gap_cnt_r;
        load_s         = 1'b0;
        shift_s        = 1'b0;
        if (en) begin
            case (state_r)
                IDLE: begin
                    if (hold_full_r) begin
                        load_s       = 1'b1;
                        state_next_s = SHIFT;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                SHIFT: begin
                    if (!core_last_s) begin
                        shift_s = 1'b1;
                    end else if (HAS_GAP) begin
                        shift_s        = 1'b1;
                        state_next_s   = piso_tx_pkg::GAP;
                        gap_cnt_next_s = 4'd0;
                    end else if (hold_full_r) begin
                        load_s       = 1'b1;
                        state_next_s = SHIFT;
                    end else begin
                        shift_s      = 1'b1;
                        state_next_s = IDLE;
                    end
                end
                piso_tx_pkg::GAP: begin
                    if (gap_cnt_r != GAP_LAST) begin
                        gap_cnt_next_s = gap_cnt_r + 4'd1;
                    end else if (hold_full_r) begin
                        load_s       = 1'b1;
                        state_next_s = SHIFT;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Accept and load never coincide: din_ready is low whenever the holding register is full.
    always_comb begin
        hold_full_next_s = hold_full_r;
        if (accept_s) begin
            hold_full_next_s = 1'b1;
        end else if (load_s) begin
            hold_full_next_s = 1'b0;
        end else begin
            hold_full_next_s = hold_full_r;
        end
    end

    // FSM, holding register and registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            gap_cnt_r    <= 4'd0;
            hold_word_r  <= {WIDTH{1'b0}};
            hold_dir_r   <= 1'b0;
            hold_full_r  <= 1'b0;
            din_ready_r  <= 1'b1;
            sout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            gap_cnt_r    <= gap_cnt_next_s;
            hold_full_r  <= hold_full_next_s;
            din_ready_r  <= ~hold_full_next_s;
            sout_valid_r <= (state_next_s == SHIFT);
            busy_r       <= (state_next_s != IDLE) | hold_full_next_s;
            if (accept_s) begin
                hold_word_r <= din;
                hold_dir_r  <= din_dir;
            end else begin
                hold_word_r <= hold_word_r;
                hold_dir_r  <= hold_dir_r;
            end
        end
    end

    tx_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .shift  (shift_s),
        .word   (hold_word_r),
        .dir    (hold_dir_r),
        .tx_bit (core_bit_s),
        .first  (core_first_s),
        .last   (core_last_s)
    );

    assign din_ready   = din_ready_r;
    assign sout        = core_bit_s;
    assign sout_valid  = sout_valid_r;
    assign frame_start = core_first_s;
    assign frame_last  = core_last_s;
    assign busy        = busy_r;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: two instances (GAP=0 and GAP=2) share random stimulus and are
// checked every cycle against a word/bit queue reference model, plus directed frame checks.
module tb_piso_serial_tx;

    localparam int W    = 4;
    localparam int NDUT = 2;

    typedef struct packed {
        logic act;
        logic vld;
        logic sd;
        logic fs;
        logic fl;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_dir;
    logic         din_valid;
    logic         en;

    logic din_ready_w  [NDUT];
    logic sout_w       [NDUT];
    logic sout_valid_w [NDUT];
    logic fs_w         [NDUT];
    logic fl_w         [NDUT];
    logic busy_w       [NDUT];

    exp_t         cur_m  [NDUT];
    exp_t         emit_q [NDUT][$];
    logic [W:0]   held_q [NDUT][$];

    int checks = 0;
    int errors = 0;
    int fl_count0 = 0;

    piso_serial_tx #(.WIDTH(W), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .din(din), .din_dir(din_dir), .din_valid(din_valid),
        .din_ready(din_ready_w[0]), .en(en), .sout(sout_w[0]), .sout_valid(sout_valid_w[0]),
        .frame_start(fs_w[0]), .frame_last(fl_w[0]), .busy(busy_w[0])
    );

    piso_serial_tx #(.WIDTH(W), .GAP(2)) u_dut1 (
        .clk(clk), .rst(rst), .din(din), .din_dir(din_dir), .din_valid(din_valid),
        .din_ready(din_ready_w[1]), .en(en), .sout(sout_w[1]), .sout_valid(sout_valid_w[1]),
        .frame_start(fs_w[1]), .frame_last(fl_w[1]), .busy(busy_w[1])
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            cur_m[i] = '0;
            emit_q[i].delete();
            held_q[i].delete();
        end
    endtask

    // One rising edge of the reference: an enabled edge shows the next queued bit/gap slot,
    // expanding a held word into its bit sequence when the queue has run dry.
    task automatic model_edge(input int i);
        logic       acc;
        logic [W:0] w;
        exp_t       t;
        acc = din_valid && (held_q[i].size() == 0);
        if (en) begin
            if (emit_q[i].size() > 0) begin
                cur_m[i] = emit_q[i].pop_front();
            end else if (held_q[i].size() > 0) begin
                w = held_q[i].pop_front();
                for (int k = 0; k < W; k++) begin
                    t.act = 1'b1;
                    t.vld = 1'b1;
                    t.sd  = w[W] ? w[k] : w[W-1-k];
                    t.fs  = (k == 0);
                    t.fl  = (k == W - 1);
                    emit_q[i].push_back(t);
                end
                for (int g = 0; g < gap_of(i); g++) begin
                    t = '0;
                    t.act = 1'b1;
                    emit_q[i].push_back(t);
                end
                cur_m[i] = emit_q[i].pop_front();
            end else begin
                cur_m[i] = '0;
            end
        end
        if (acc) held_q[i].push_back({din_dir, din});
    endtask

    task automatic compare_all(input string ph);
        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("%s.d%0d.sout", ph, i), sout_w[i], cur_m[i].sd);
            check_eq($sformatf("%s.d%0d.sout_valid", ph, i), sout_valid_w[i], cur_m[i].vld);
            check_eq($sformatf("%s.d%0d.frame_start", ph, i), fs_w[i], cur_m[i].fs);
            check_eq($sformatf("%s.d%0d.frame_last", ph, i), fl_w[i], cur_m[i].fl);
            check_eq($sformatf("%s.d%0d.din_ready", ph, i), din_ready_w[i],
                     held_q[i].size() == 0);
            check_eq($sformatf("%s.d%0d.busy", ph, i), busy_w[i],
                     cur_m[i].act || (held_q[i].size() > 0));
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic dr, input logic e,
                        input string ph);
        din_valid = v;
        din       = d;
        din_dir   = dr;
        en        = e;
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) model_edge(i);
        #1;
        compare_all(ph);
        if (fl_w[0] === 1'b1) fl_count0++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 4'h0, 1'b0, 1'b1, "idle");
    endtask

    // Reset asserted between edges: outputs must clear before the next edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("rst_async");
        @(posedge clk);
        #1;
        compare_all("rst_hold");
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] got4;
        logic [7:0] got8;
        logic [9:0] vld0;
        logic [9:0] vld1;
        int         seen;

        rst       = 1'b0;
        din       = 4'h0;
        din_dir   = 1'b0;
        din_valid = 1'b0;
        en        = 1'b0;
        do_reset();
        idle(6);

        // MSB first: 1011 -> 1,0,1,1
        step(1'b1, 4'b1011, 1'b0, 1'b1, "msb_acc");
        got4 = 4'h0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'h0, 1'b0, 1'b1, "msb");
            got4 = {got4[2:0], sout_w[0]};
        end
        check_eq("msb_seq", {28'h0, got4}, 32'h0000000b);
        idle(6);

        // LSB first: 1011 -> 1,1,0,1; ready again by cycle 2
        step(1'b1, 4'b1011, 1'b1, 1'b1, "lsb_acc");
        got4 = 4'h0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'h0, 1'b0, 1'b1, "lsb");
            got4 = {got4[2:0], sout_w[0]};
            if (k == 1) check_eq("lsb_ready_c2", {31'h0, din_ready_w[0]}, 32'h1);
        end
        check_eq("lsb_seq", {28'h0, got4}, 32'h0000000d);
        idle(6);

        // Back-to-back: 1011 (msb) at edge 0, 0110 (lsb) at edge 2
        step(1'b1, 4'b1011, 1'b0, 1'b1, "b2b_acc0");
        got8 = 8'h0;
        vld0 = 10'h0;
        vld1 = 10'h0;
        for (int k = 0; k < 10; k++) begin
            if (k == 1) step(1'b1, 4'b0110, 1'b1, 1'b1, "b2b_acc1");
            else        step(1'b0, 4'h0, 1'b0, 1'b1, "b2b");
            if (k < 8) got8 = {got8[6:0], sout_w[0]};
            vld0 = {vld0[8:0], sout_valid_w[0]};
            vld1 = {vld1[8:0], sout_valid_w[1]};
        end
        check_eq("b2b_bits", {24'h0, got8}, 32'h000000b6);
        check_eq("b2b_valid_gap0", {22'h0, vld0}, 32'h000003fc);
        check_eq("b2b_valid_gap2", {22'h0, vld1}, 32'h000003cf);
        idle(8);

        // Stall after the second bit of 1011
        fl_count0 = 0;
        step(1'b1, 4'b1011, 1'b0, 1'b1, "stall_acc");
        step(1'b0, 4'h0, 1'b0, 1'b1, "stall_b1");
        step(1'b0, 4'h0, 1'b0, 1'b1, "stall_b2");
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'h0, 1'b0, 1'b0, "stall_en0");
            check_eq("stall_sout", {31'h0, sout_w[0]}, 32'h0);
            check_eq("stall_valid", {31'h0, sout_valid_w[0]}, 32'h1);
        end
        step(1'b0, 4'h0, 1'b0, 1'b1, "stall_b3");
        check_eq("stall_resume3", {31'h0, sout_w[0]}, 32'h1);
        step(1'b0, 4'h0, 1'b0, 1'b1, "stall_b4");
        check_eq("stall_resume4", {31'h0, sout_w[0]}, 32'h1);
        idle(6);
        check_eq("stall_last_once", fl_count0, 32'h1);

        // Reset during the third bit with a second word held
        step(1'b1, 4'b1011, 1'b0, 1'b1, "mid_acc0");
        step(1'b0, 4'h0, 1'b0, 1'b1, "mid_b1");
        step(1'b1, 4'b0101, 1'b0, 1'b1, "mid_acc1");
        step(1'b0, 4'h0, 1'b0, 1'b1, "mid_b3");
        check_eq("mid_held", {31'h0, busy_w[0]}, 32'h1);
        do_reset();
        check_eq("mid_ready", {31'h0, din_ready_w[0]}, 32'h1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 4'h0, 1'b0, 1'b1, "post_rst");
            if (sout_valid_w[0] === 1'b1 || sout_valid_w[1] === 1'b1) seen++;
        end
        check_eq("post_rst_quiet", seen, 32'h0);

        // Random traffic with occasional stalls
        for (int n = 0; n < 800; n++) begin
            step(1'($urandom_range(0, 99) < 45), 4'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) != 0), "rnd");
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
